// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port data memory (IDLE -> ACCESS -> RESP).
// Define ARB_FIXED_PRIO_EN to make port 0 always win ties (port 1 may starve).
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [AW-1:0] lat_adr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;
  logic          lat_id;
  logic          winner;

`ifdef ARB_FIXED_PRIO_EN
  always_comb winner = ~req[0];
`else
  logic last_served;

  // On a tie the port that was not served last wins.
  always_comb begin
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_served;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      rdata     <= '0;
      lat_adr   <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_served <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            lat_adr   <= winner ? adr1 : adr0;
            lat_wdata <= winner ? wdata1 : wdata0;
            lat_we    <= we[winner];
            lat_id    <= winner;
            gnt       <= winner ? 2'b10 : 2'b01;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we) rdata <= mem_rdata;
          gnt    <= 2'b00;
          rvalid <= lat_id ? 2'b10 : 2'b01;
`ifndef ARB_FIXED_PRIO_EN
          last_served <= lat_id;
`endif
          state  <= RESP;
        end
        RESP: begin
          rvalid <= 2'b00;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe is gated by rst_n so an aborted transaction never commits.
  assign mem_wen  = (state == ACCESS) & lat_we & rst_n;
  assign mem_adr  = lat_adr;
  assign mem_data = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random two-port traffic
// compared against a transaction-level reference model and a reference memory image.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [9:0]  adr0, adr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic [9:0]  mem_adr;
  logic [15:0] mem_data;
  logic        mem_wen;
  logic [15:0] mem_rdata;

  logic [15:0] phys_mem [1024];
  logic [15:0] ref_mem  [1024];

  int n_vectors = 0;
  int n_miscompares = 0;

  int          cyc = 0;
  int          dec_cycle = -100;
  int          next_free = 0;
  int          dec_id = 0;
  int          last_served = 1;
  logic        dec_we = 1'b0;
  logic [9:0]  dec_adr = '0;
  logic [15:0] dec_data = '0;
  logic [15:0] ref_rdata = '0;

  mem_arbiter #(.AW(10), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_adr(mem_adr), .mem_data(mem_data), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    if (i >= 10 && i <= 19) return 16'(i - 9);
    return 16'((i * 311) ^ 16'hA5C3);
  endfunction

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = phys_mem[mem_adr];
  initial begin
    for (int i = 0; i < 1024; i++) phys_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_wen) phys_mem[mem_adr] <= mem_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Transaction-level model: a request sampled at edge k is granted after k, completes
  // after k+1, and the arbiter can sample again at edge k+3.
  task automatic modelStep();
    int id;
    if (!rst_n) begin
      dec_cycle   = -100;
      next_free   = cyc + 1;
      last_served = 1;
      ref_rdata   = '0;
    end else begin
      if (cyc == dec_cycle + 1) begin
        if (dec_we) ref_mem[dec_adr] = dec_data;
        else        ref_rdata = ref_mem[dec_adr];
      end
      if (cyc >= next_free && req != 2'b00) begin
        if (req == 2'b01)      id = 0;
        else if (req == 2'b10) id = 1;
        else begin
`ifdef ARB_FIXED_PRIO_EN
          id = 0;
`else
          id = 1 - last_served;
`endif
        end
        dec_cycle   = cyc;
        dec_id      = id;
        dec_we      = we[id];
        dec_adr     = (id == 1) ? adr1 : adr0;
        dec_data    = (id == 1) ? wdata1 : wdata0;
        next_free   = cyc + 3;
        last_served = id;
      end
    end
  endtask

  task automatic checkAll();
    logic [1:0] onehot;
    onehot = (dec_id == 1) ? 2'b10 : 2'b01;
    checkOutput("gnt",     gnt,     (cyc == dec_cycle)     ? onehot : 2'b00);
    checkOutput("rvalid",  rvalid,  (cyc == dec_cycle + 1) ? onehot : 2'b00);
    checkOutput("mem_wen", mem_wen, (cyc == dec_cycle) && dec_we && rst_n);
    checkOutput("rdata",   rdata,   ref_rdata);
    if (cyc == dec_cycle) begin
      checkOutput("mem_adr", mem_adr, dec_adr);
      if (dec_we) checkOutput("mem_data", mem_data, dec_data);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] w,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1);
    rst_n = r; req = rq; we = w; adr0 = a0; adr1 = a1; wdata0 = d0; wdata1 = d1;
    @(posedge clk);
    cyc++;
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  function automatic logic [9:0] rand_adr();
    if ($urandom_range(1) == 1) return 10'($urandom_range(31));
    return 10'($urandom_range(1023));
  endfunction

  logic [1:0]  p_req, p_we;
  logic [9:0]  p_adr [2];
  logic [15:0] p_dat [2];
  logic        p_rst;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    // Reset, then single read of a preset word.
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b01, 2'b00, 12, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("t1_rdata", rdata, 16'd3);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);

    // Port 1 writes, port 0 reads the same word back.
    applyStimulus(1, 2'b10, 2'b10, 0, 20, 0, 16'h00AB);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b01, 2'b00, 20, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("t2_rdata", rdata, 16'h00AB);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);

    // Both ports held high after reset.
    applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 2'b11, 2'b00, 10, 19, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);

    // Port 0 alone held high.
    for (int i = 0; i < 9; i++) applyStimulus(1, 2'b01, 2'b00, 11, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);

    // Reset during the ACCESS cycle of a write aborts it.
    applyStimulus(1, 2'b10, 2'b10, 0, 15, 0, 16'hFFFF);
    applyStimulus(0, 2'b10, 2'b10, 0, 15, 0, 16'hFFFF);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("t5_m15", phys_mem[15], 16'd6);
    applyStimulus(1, 2'b01, 2'b00, 15, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("t5_rdata", rdata, 16'd6);

    // Random traffic with occasional resets.
    p_req = 2'b00; p_we = 2'b00;
    p_adr[0] = '0; p_adr[1] = '0; p_dat[0] = '0; p_dat[1] = '0;
    for (int n = 0; n < 1500; n++) begin
      if (dec_cycle == cyc) p_req[dec_id] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && $urandom_range(1) == 1) begin
          p_req[i] = 1'b1;
          p_we[i]  = 1'($urandom_range(1));
          p_adr[i] = rand_adr();
          p_dat[i] = 16'($urandom);
        end
      end
      p_rst = ($urandom_range(49) != 0);
      applyStimulus(p_rst, p_req, p_we, p_adr[0], p_adr[1], p_dat[0], p_dat[1]);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 1024; i++) checkOutput($sformatf("mem[%0d]", i), phys_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
